timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped countdown timer that sits on the far side of the CPU data bus. It decodes the CPU's word address, byte enables and write data, and returns read data combinationally in the same cycle as the M-stage access. It also drives one of the CPU's external interrupt lines (one bit of `HWInt[5:0]`) when a countdown expires. The block has a four-state FSM, a 32-bit down-counter, byte-lane register writes and an optional prescaler.

## Interface
- `BASE`, default `32'h0000_7F00`: base byte address of the register window. Must be 16-byte aligned.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `dev_addr` input 32: byte address from the CPU data port.
- `dev_byteen` input 4: byte write enables; `4'b0000` means no write.
- `dev_wdata` input 32: write data, already lane-aligned by the CPU.
- `dev_rdata` output 32: combinational read data for `dev_addr`.
- `irq` output 1: interrupt request, connected to one `HWInt` bit.

## Operation
- **Decode.** `hit` = (`dev_addr[31:4] == BASE[31:4]`) && (`dev_addr[3:2] != 2'b11`).
  - Offset 0x0 is CTRL, 0x4 is PRESET, 0x8 is COUNT.
  - If `hit` is 0, `dev_rdata` is 0 and writes are ignored.
- **CTRL register.**
  - bit0 EN: enable.
  - bits[2:1] MODE: `00` = one-shot, `01` = auto-reload, `1x` = treated as one-shot.
  - bit3 IM: interrupt mask; 1 allows `irq`.
  - All other bits read 0; writes to them are ignored.
- **PRESET register.** Read/write.
- **COUNT register.** Read-only; writes are ignored.
- **Byte-lane writes.** Lane k of the addressed register is updated only when `dev_byteen[k]` is 1.
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE; COUNT holds.
    - Else if COUNT > 1, decrement COUNT.
    - Else set COUNT <= 0, set the interrupt flag, and go to INT.
  - INT, one-shot mode: clear EN, go to IDLE, flag stays set.
  - INT, auto-reload mode: clear the flag, go to LOAD.
- **Interrupt output.** `irq` = IM & flag.
  - In one-shot mode the flag is sticky. It is cleared by any write hitting CTRL or PRESET.
  - In auto-reload mode `irq` is a pulse exactly one cycle wide.
- **Simultaneous events.** A bus write to CTRL in the same edge as INT's EN clear takes priority: the written EN value wins. The flag clear caused by a write takes priority over a flag set in the same edge.
- **PRESET during CNT.** A write to PRESET does not affect the running COUNT; it takes effect at the next LOAD.
- **Reset.**
  - CTRL, PRESET, COUNT and the flag are 0.
  - State is IDLE.
  - `irq` is 0 and `dev_rdata` is 0 for any address.
  - Reset mid-count abandons the count with no pending interrupt.

## Timing
- **Reads.** `dev_rdata` is purely combinational from the current register values; zero-cycle latency. A read and a write to the same register in one cycle return the old value.
- **Writes.** Visible on `dev_rdata` from the cycle after the edge.
- **FSM latency.** The FSM samples register values before the edge; a CTRL write at edge e0 is acted on at e1.
- **One-shot timeline.** Let N = PRESET ≥ 1 and CTRL is written at edge e0.
  - e1: IDLE → LOAD.
  - e2: COUNT = N.
  - e(N+2): enter INT; `irq` is high after e(N+2).
  - PRESET = 0 behaves like N = 1.
- **Auto-reload period.** N+2 cycles between `irq` pulses.
- **EN cleared while counting.** Setting EN=0 during CNT freezes COUNT from the edge after the write. Re-enabling goes through LOAD, so COUNT restarts from PRESET.
- **Wrap-around.** COUNT never wraps: its minimum is 0, and PRESET = 0xFFFF_FFFF counts the full range.

## Configuration
- **`TC_PRESCALER_EN` defined:**
  - CTRL bits[11:4] form PSC (read/write).
  - In CNT, COUNT changes (decrements, or goes to 0 and enters INT) only once every PSC+1 cycles.
  - An internal 8-bit prescale counter is cleared in LOAD and whenever CNT is left.
  - The one-shot `irq` timing becomes e(2 + N·(PSC+1)).
- **`TC_PRESCALER_EN` undefined:**
  - CTRL bits[11:4] read 0 and writes to them are ignored.
  - COUNT decrements every cycle, exactly as described above.

## Test plan
- **Reset values.** Assert `reset` for 2 cycles, then read offsets 0x0, 0x4 and 0x8 → all 0, `irq` = 0.
- **One-shot.** Write PRESET=3, then CTRL=0x9 at e0 → COUNT reads 3, 2, 1, 0 after e2–e5. `irq` is 1 after e5 and stays 1. CTRL reads 0x8 after e6. A write of CTRL=0 drops `irq` on the next cycle.
- **Auto-reload.** PRESET=2, CTRL=0xB → `irq` pulses 1 cycle wide every 4 cycles. With IM=0 (CTRL=0x3), `irq` stays 0 while COUNT still cycles.
- **Byte lanes.** PRESET=0xAABBCCDD, then write 0x11223344 with byteen=`4'b0100` → PRESET reads 0xAA22CCDD. A write to COUNT is ignored; a write to 0xC or outside BASE leaves all registers unchanged and reads 0.
- **Boundaries.**
  - Clear EN mid-count at COUNT=5 → COUNT holds 5 and no `irq`.
  - Set EN again → COUNT reloads from PRESET.
  - `reset` during CNT → next cycle state IDLE, COUNT=0, `irq`=0.
- **Prescaler (`TC_PRESCALER_EN` only).** PSC=1, PRESET=2, one-shot, write at e0 → `irq` rises after e6.

Source files
------------

// File: rtl/timer_counter_if.sv
// CPU data-port bundle for timer_counter.
// The CPU drives address, byte enables and write data; the timer returns read data and its interrupt line.
interface timer_counter_if;
  logic [31:0] dev_addr;
  logic [3:0]  dev_byteen;
  logic [31:0] dev_wdata;
  logic [31:0] dev_rdata;
  logic        irq;

  modport master (output dev_addr, dev_byteen, dev_wdata, input dev_rdata, irq);
  modport slave  (input dev_addr, dev_byteen, dev_wdata, output dev_rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit countdown timer (CTRL/PRESET/COUNT) driving one CPU interrupt line.
// Define TC_PRESCALER_EN to add an 8-bit prescaler held in CTRL[11:4].
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input logic            clk,
  input logic            reset,
  timer_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

`ifdef TC_PRESCALER_EN
  localparam logic [31:0] CTRL_MASK = 32'h0000_0FFF;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`endif

  state_t      state, state_next;
  logic [31:0] ctrl, preset, count, count_next;
  logic        flag;
  logic        flag_set, flag_clr, en_clr, tick;
  logic        hit, wr, wr_ctrl, wr_preset;
  logic [31:0] lane_mask, ctrl_wmask, ctrl_base;
  logic        addr_unused;

  assign addr_unused = ^bus.dev_addr[1:0];
  assign hit       = (bus.dev_addr[31:4] == BASE[31:4]) && (bus.dev_addr[3:2] != 2'b11);
  assign wr        = hit && (bus.dev_byteen != 4'b0000);
  assign wr_ctrl   = wr && (bus.dev_addr[3:2] == 2'b00);
  assign wr_preset = wr && (bus.dev_addr[3:2] == 2'b01);
  assign lane_mask = {{8{bus.dev_byteen[3]}}, {8{bus.dev_byteen[2]}},
                      {8{bus.dev_byteen[1]}}, {8{bus.dev_byteen[0]}}};
  assign ctrl_wmask = wr_ctrl ? (lane_mask & CTRL_MASK) : 32'h0;

  // The FSM's EN clear is applied first so a same-edge bus write to EN overrides it.
  assign ctrl_base = en_clr ? {ctrl[31:1], 1'b0} : ctrl;

`ifdef TC_PRESCALER_EN
  logic [7:0] psc_cnt;

  assign tick = (psc_cnt >= ctrl[11:4]);

  always_ff @(posedge clk) begin
    if (reset || (state != CNT) || !ctrl[0] || tick)
      psc_cnt <= 8'd0;
    else
      psc_cnt <= psc_cnt + 8'd1;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_next = state;
    count_next = count;
    flag_set   = 1'b0;
    flag_clr   = 1'b0;
    en_clr     = 1'b0;
    case (state)
      IDLE: if (ctrl[0]) state_next = LOAD;
      LOAD: begin
        count_next = preset;
        state_next = CNT;
      end
      CNT: begin
        if (!ctrl[0]) begin
          state_next = IDLE;
        end else if (tick) begin
          if (count > 32'd1) begin
            count_next = count - 32'd1;
          end else begin
            count_next = 32'd0;
            flag_set   = 1'b1;
            state_next = INT;
          end
        end
      end
      INT: begin
        if (ctrl[2:1] == 2'b01) begin
          flag_clr   = 1'b1;
          state_next = LOAD;
        end else begin
          en_clr     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ctrl   <= 32'h0;
      preset <= 32'h0;
      count  <= 32'h0;
      flag   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      ctrl  <= (ctrl_base & ~ctrl_wmask) | (bus.dev_wdata & ctrl_wmask);
      if (wr_preset)
        preset <= (preset & ~lane_mask) | (bus.dev_wdata & lane_mask);
      // A register write acknowledges the interrupt and beats a same-edge expiry.
      if (wr_ctrl || wr_preset)
        flag <= 1'b0;
      else if (flag_set)
        flag <= 1'b1;
      else if (flag_clr)
        flag <= 1'b0;
    end
  end

  always_comb begin
    bus.dev_rdata = 32'h0;
    if (!reset && hit) begin
      case (bus.dev_addr[3:2])
        2'b00:   bus.dev_rdata = ctrl;
        2'b01:   bus.dev_rdata = preset;
        2'b10:   bus.dev_rdata = count;
        default: bus.dev_rdata = 32'h0;
      endcase
    end
  end

  assign bus.irq = !reset && ctrl[3] && flag;
endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: decode/byte-lane vector table, corner-case
// sequences, and randomized runs checked against closed-form countdown timing.
module tb_timer_counter;
  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE;
  localparam logic [31:0] A_PRESET = BASE + 32'd4;
  localparam logic [31:0] A_COUNT  = BASE + 32'd8;
  localparam logic [31:0] A_RSVD   = BASE + 32'd12;
`ifdef TC_PRESCALER_EN
  localparam logic [31:0] CTRL_BITS = 32'h0000_0FFF;
`else
  localparam logic [31:0] CTRL_BITS = 32'h0000_000F;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd_addr;
    logic [31:0] expected;
  } vec_t;

  logic clk;
  logic reset;
  int   check_count;
  int   pass_count;
  vec_t vecs [12];
  logic [31:0] addr_pool [5];

  timer_counter_if bus ();

  timer_counter #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    bus.dev_addr   = addr;
    bus.dev_byteen = be;
    bus.dev_wdata  = data;
    tick();
    bus.dev_byteen = 4'b0000;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
    bus.dev_addr   = addr;
    bus.dev_byteen = 4'b0000;
    #1;
    data = bus.dev_rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkReg(input string name, input logic [31:0] addr, input logic [31:0] expected);
    logic [31:0] data;
    readReg(addr, data);
    checkOutput(name, data, expected);
  endtask

  task automatic checkIrq(input string name, input logic expected);
    checkOutput(name, {31'b0, bus.irq}, {31'b0, expected});
  endtask

  initial begin
    logic [31:0] m_preset;
    logic [31:0] rd;
    logic        saw_irq, saw_two, saw_zero;

    check_count    = 0;
    pass_count     = 0;
    bus.dev_addr   = 32'h0;
    bus.dev_byteen = 4'b0000;
    bus.dev_wdata  = 32'h0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkReg("reset_ctrl", A_CTRL, 32'h0);
    checkReg("reset_preset", A_PRESET, 32'h0);
    checkReg("reset_count", A_COUNT, 32'h0);
    checkIrq("reset_irq", 1'b0);

    vecs[0]  = '{A_PRESET, 4'b1111, 32'hAABB_CCDD, A_PRESET, 32'hAABB_CCDD};
    vecs[1]  = '{A_PRESET, 4'b0100, 32'h1122_3344, A_PRESET, 32'hAA22_CCDD};
    vecs[2]  = '{A_PRESET, 4'b0001, 32'h0000_00EE, A_PRESET, 32'hAA22_CCEE};
    vecs[3]  = '{A_PRESET, 4'b0000, 32'hFFFF_FFFF, A_PRESET, 32'hAA22_CCEE};
    vecs[4]  = '{A_COUNT,  4'b1111, 32'h1234_5678, A_COUNT,  32'h0};
    vecs[5]  = '{A_RSVD,   4'b1111, 32'h0000_0001, A_RSVD,   32'h0};
    vecs[6]  = '{32'h0000_8F04, 4'b1111, 32'hFFFF_FFFF, A_PRESET, 32'hAA22_CCEE};
    vecs[7]  = '{32'h0000_8F04, 4'b0000, 32'h0, 32'h0000_8F04, 32'h0};
    vecs[8]  = '{A_CTRL, 4'b1111, 32'hFFFF_FFF6, A_CTRL, 32'hFFFF_FFF6 & CTRL_BITS};
    vecs[9]  = '{A_CTRL, 4'b0010, 32'h0000_0A00, A_CTRL, 32'h0000_0AF6 & CTRL_BITS};
    vecs[10] = '{A_CTRL, 4'b1111, 32'h0, A_CTRL, 32'h0};
    vecs[11] = '{A_CTRL, 4'b0000, 32'h0, 32'h0000_7F05, 32'hAA22_CCEE};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].be, vecs[i].wdata);
      checkReg($sformatf("vec%0d", i), vecs[i].rd_addr, vecs[i].expected);
    end

    // Random PRESET lane writes; only hits on PRESET may change the modelled value.
    m_preset = 32'hAA22_CCEE;
    addr_pool = '{A_PRESET, A_PRESET, A_COUNT, A_RSVD, 32'h0000_7F44};
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, d;
      logic [3:0]  be;
      a  = addr_pool[$urandom_range(0, 4)];
      be = 4'($urandom_range(0, 15));
      d  = $urandom;
      applyStimulus(a, be, d);
      if (a == A_PRESET)
        for (int b = 0; b < 4; b++)
          if (be[b]) m_preset[8*b +: 8] = d[8*b +: 8];
      checkReg("rand_preset", A_PRESET, m_preset);
    end

    applyStimulus(A_PRESET, 4'hF, 32'd3);
    applyStimulus(A_CTRL, 4'hF, 32'h9);
    tick();
    for (int k = 2; k <= 5; k++) begin
      tick();
      checkReg($sformatf("os_count_e%0d", k), A_COUNT, 32'(5 - k));
      checkIrq($sformatf("os_irq_e%0d", k), k == 5);
    end
    tick();
    checkIrq("os_irq_sticky", 1'b1);
    checkReg("os_ctrl_en_cleared", A_CTRL, 32'h8);
    applyStimulus(A_CTRL, 4'hF, 32'h0);
    checkIrq("os_irq_ack", 1'b0);

    applyStimulus(A_PRESET, 4'hF, 32'd2);
    applyStimulus(A_CTRL, 4'hF, 32'hB);
    for (int k = 1; k <= 13; k++) begin
      tick();
      checkIrq($sformatf("ar_irq_e%0d", k), (k >= 4) && ((k - 4) % 4 == 0));
    end
    applyStimulus(A_CTRL, 4'hF, 32'h3);
    saw_irq  = 1'b0;
    saw_two  = 1'b0;
    saw_zero = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      saw_irq = saw_irq | bus.irq;
      readReg(A_COUNT, rd);
      if (rd == 32'd2) saw_two = 1'b1;
      if (rd == 32'd0) saw_zero = 1'b1;
    end
    checkOutput("ar_masked_irq", {31'b0, saw_irq}, 32'd0);
    checkOutput("ar_masked_counting", {30'b0, saw_two, saw_zero}, 32'd3);
    applyStimulus(A_CTRL, 4'hF, 32'h0);
    repeat (4) tick();

    applyStimulus(A_PRESET, 4'hF, 32'd8);
    applyStimulus(A_CTRL, 4'hF, 32'h9);
    repeat (4) tick();
    applyStimulus(A_CTRL, 4'hF, 32'h8);
    checkReg("hold_count_at_write", A_COUNT, 32'd5);
    repeat (3) tick();
    checkReg("hold_count", A_COUNT, 32'd5);
    checkIrq("hold_irq", 1'b0);
    applyStimulus(A_PRESET, 4'hF, 32'd4);
    applyStimulus(A_CTRL, 4'hF, 32'h9);
    tick();
    tick();
    checkReg("reload_count", A_COUNT, 32'd4);
    tick();
    checkReg("reload_decrement", A_COUNT, 32'd3);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkReg("midreset_count", A_COUNT, 32'h0);
    checkReg("midreset_ctrl", A_CTRL, 32'h0);
    checkReg("midreset_preset", A_PRESET, 32'h0);
    checkIrq("midreset_irq", 1'b0);
    repeat (6) tick();
    checkReg("midreset_count_later", A_COUNT, 32'h0);
    checkIrq("midreset_irq_later", 1'b0);

    // CTRL write on the same edge as one-shot INT: written EN survives, write clears the flag.
    applyStimulus(A_PRESET, 4'hF, 32'd1);
    applyStimulus(A_CTRL, 4'hF, 32'h9);
    repeat (3) tick();
    checkIrq("race_irq_before", 1'b1);
    applyStimulus(A_CTRL, 4'hF, 32'h9);
    checkReg("race_ctrl_en_kept", A_CTRL, 32'h9);
    checkIrq("race_irq_cleared", 1'b0);
    applyStimulus(A_CTRL, 4'hF, 32'h0);
    repeat (4) tick();

`ifdef TC_PRESCALER_EN
    applyStimulus(A_PRESET, 4'hF, 32'd2);
    applyStimulus(A_CTRL, 4'hF, 32'h19);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkIrq($sformatf("psc_irq_e%0d", k), k >= 6);
    end
    applyStimulus(A_CTRL, 4'hF, 32'h0);
    repeat (4) tick();
`endif

    // Randomized runs: expected COUNT/irq come from the N+2 timeline and period arithmetic.
    for (int r = 0; r < 16; r++) begin
      int   n, neff, mode, period, cycles, ph, exp_cnt;
      logic im, auto_m, exp_irq;
      n      = int'($urandom_range(0, 6));
      mode   = int'($urandom_range(0, 3));
      im     = 1'($urandom_range(0, 1));
      auto_m = (mode == 1);
      neff   = (n == 0) ? 1 : n;
      period = neff + 2;
      cycles = auto_m ? 3 * period + 2 : neff + 4;
      applyStimulus(A_PRESET, 4'hF, 32'(n));
      applyStimulus(A_CTRL, 4'hF, 32'(1 + mode * 2 + (im ? 8 : 0)));
      for (int k = 1; k <= cycles; k++) begin
        tick();
        exp_irq = 1'b0;
        if (k >= 2) begin
          ph = auto_m ? (k - 2) % period : (k - 2);
          exp_cnt = (ph <= neff && n > ph) ? n - ph : 0;
          exp_irq = auto_m ? (im && ph == neff) : (im && k >= neff + 2);
          checkReg("rand_count", A_COUNT, 32'(exp_cnt));
        end
        checkIrq("rand_irq", exp_irq);
      end
      applyStimulus(A_CTRL, 4'hF, 32'h0);
      repeat (4) tick();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
